// File: rtl/i2c_fifo_pkg.sv
// i2c_fifo_pkg: shared defaults and helpers for the I2C datapath FIFO
package i2c_fifo_pkg;
  localparam int FIFO_DATA_W     = 8;
  localparam int FIFO_DEPTH_LOG2 = 4;
  localparam int FIFO_DEPTH      = 1 << FIFO_DEPTH_LOG2;
  function automatic int clog2(input int v);
    clog2 = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) clog2 = i + 1;
  endfunction
endpackage

// File: rtl/i2c_fifo_ram.sv
// i2c_fifo_ram: 1W/1R storage array; registered read, or combinational read when I2C_FIFO_FWFT_EN is defined
module i2c_fifo_ram import i2c_fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
`ifndef I2C_FIFO_FWFT_EN
  input  logic              reset,
  input  logic              re_i,
`endif
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  // storage is never cleared; only the read register sees reset
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
`ifdef I2C_FIFO_FWFT_EN
  assign rdata_o = mem_q[raddr_i];
`else
  logic [DATA_W-1:0] rdata_q;
  // read register: loads on an accepted read, otherwise holds the last word
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
`endif
endmodule

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: synchronous FIFO with occupancy count, threshold flags and sticky errors; I2C_FIFO_FWFT_EN selects first-word-fall-through
module i2c_sync_fifo import i2c_fifo_pkg::*; #(
  parameter int DATA_W     = FIFO_DATA_W,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  rd,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AF_C    = AFULL_TH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AE_C    = AEMPTY_TH[DEPTH_LOG2:0];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  we, re;

  assign full         = count_q == DEPTH_C;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_C;
  assign almost_empty = count_q <= AE_C;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign we           = wr & ~full;
  assign re           = rd & ~empty;

  // occupancy and sticky-error next state; a new error beats a same-cycle clear
  always_comb begin
    count_d = (we & ~re) ? count_q + 1'b1 : (re & ~we) ? count_q - 1'b1 : count_q;
    ovf_d   = (wr & full) | (ovf_q & ~clr_err);
    udf_d   = (rd & empty) | (udf_q & ~clr_err);
  end

  // pointers wrap naturally; count carries the extra bit that separates full from empty
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (we) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (re) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end

`ifdef I2C_FIFO_FWFT_EN
  assign rd_valid = ~empty;
  i2c_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we_i(we), .waddr_i(wr_ptr_q), .wdata_i(data_in),
    .raddr_i(rd_ptr_q), .rdata_o(data_out)
  );
`else
  logic rd_valid_q;
  // one-cycle pulse marking the edge where data_out was reloaded
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd_valid_q <= 1'b0;
    else rd_valid_q <= re;
  assign rd_valid = rd_valid_q;
  i2c_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .reset(reset), .re_i(re), .we_i(we), .waddr_i(wr_ptr_q),
    .wdata_i(data_in), .raddr_i(rd_ptr_q), .rdata_o(data_out)
  );
`endif
endmodule

// File: tb/tb_i2c_sync_fifo.sv
// tb_i2c_sync_fifo: directed stimulus against a queue-based reference model plus literal spot checks
module tb_i2c_sync_fifo;
  logic       clk = 0, reset = 0, wr = 0, rd = 0, clr_err = 0;
  logic [7:0] data_in = 0, data_out;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0, failures = 0;
  byte unsigned q[$];
  logic [7:0] m_dout;
  logic m_rv, m_ovf, m_udf;
  bit chk_en = 0;

  always #5 clk = ~clk;

  i2c_sync_fifo dut (
    .clk(clk), .reset(reset), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 0;
    m_rv = 0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  // apply one cycle of inputs, advance the model at the edge, return at the falling edge
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c = 0);
    bit f, e;
    wr = w; data_in = d; rd = r; clr_err = c;
    @(posedge clk);
    f = q.size() == 16;
    e = q.size() == 0;
    m_rv = r && !e;
    if (m_rv) m_dout = q.pop_front();
    if (w && !f) q.push_back(d);
    if (c) begin m_ovf = 0; m_udf = 0; end
    if (w && f) m_ovf = 1;
    if (r && e) m_udf = 1;
    @(negedge clk);
  endtask

  // every falling edge: DUT outputs against the model
  always @(negedge clk) if (chk_en) begin
    check("count", count, q.size());
    check("full", full, q.size() == 16);
    check("empty", empty, q.size() == 0);
    check("almost_full", almost_full, q.size() >= 12);
    check("almost_empty", almost_empty, q.size() <= 2);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
`ifdef I2C_FIFO_FWFT_EN
    check("rd_valid", rd_valid, q.size() != 0);
    if (q.size() != 0) check("data_out", data_out, q[0]);
`else
    check("rd_valid", rd_valid, m_rv);
    check("data_out", data_out, m_dout);
`endif
  end

  initial begin
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_flags", {overflow, underflow}, 0);
`ifndef I2C_FIFO_FWFT_EN
    check("rst_data_out", data_out, 0);
`endif
    reset = 1;
    chk_en = 1;

    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0);
      check("fill_afull", almost_full, i >= 12);
    end
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    step(1, 8'hFF, 0);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);

    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1);
`ifndef I2C_FIFO_FWFT_EN
      check("drain_data", data_out, i);
      check("drain_valid", rd_valid, 1);
`endif
    end
    check("drain_empty", empty, 1);
    step(0, 0, 1);
    check("udf_set", underflow, 1);
    check("udf_count", count, 0);
`ifndef I2C_FIFO_FWFT_EN
    check("udf_hold", data_out, 8'h10);
    check("udf_novalid", rd_valid, 0);
`endif
    step(0, 0, 0, 1);
    check("clr_both", {overflow, underflow}, 0);

    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 10; k++) step(1, 8'(8'h20 + 16 * p + k), 0);
      check("wrap_peak", count, 10);
      for (int k = 0; k < 10; k++) begin
        step(0, 0, 1);
`ifndef I2C_FIFO_FWFT_EN
        check("wrap_data", data_out, 8'h20 + 16 * p + k);
`endif
      end
      check("wrap_zero", count, 0);
    end

    for (int k = 0; k < 5; k++) step(1, 8'(8'h40 + k), 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 8'(8'h50 + k), 1);
      check("simul_count", count, 5);
`ifndef I2C_FIFO_FWFT_EN
      check("simul_data", data_out, k < 5 ? 8'h40 + k : 8'h50 + k - 5);
`endif
    end
    repeat (5) step(0, 0, 1);

    step(1, 8'h77, 1);
    check("se_count", count, 1);
    check("se_udf", underflow, 1);
    step(0, 0, 1);
`ifndef I2C_FIFO_FWFT_EN
    check("se_data", data_out, 8'h77);
`endif
    step(0, 0, 0, 1);

    for (int k = 0; k < 16; k++) step(1, 8'(8'h80 + k), 0);
    step(1, 8'hEE, 1);
    check("sf_count", count, 15);
    check("sf_ovf", overflow, 1);
`ifndef I2C_FIFO_FWFT_EN
    check("sf_data", data_out, 8'h80);
`endif
    step(0, 0, 0, 1);
    check("clr_ovf", overflow, 0);

    repeat (8) step(0, 0, 1);
    check("pre_rst_count", count, 7);
    #2 reset = 0;
    model_reset();
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_valid", rd_valid, 0);
`ifndef I2C_FIFO_FWFT_EN
    check("arst_data", data_out, 0);
`endif
    wr = 0; rd = 0;
    @(negedge clk);
    reset = 1;
    step(1, 8'h3C, 0);
    check("post_rst_count", count, 1);
    step(0, 0, 1);
`ifdef I2C_FIFO_FWFT_EN
    step(1, 8'hA5, 0);
    check("fwft_data", data_out, 8'hA5);
    check("fwft_valid", rd_valid, 1);
    step(0, 0, 1);
    check("fwft_empty", empty, 1);
`else
    check("post_rst_data", data_out, 8'h3C);
`endif
    step(0, 0, 0);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_sync_fifo.md
Name: i2c_sync_fifo

Overview:
Parametrised synchronous FIFO. Successor to the fixed 8x16 byte FIFO in the I2C datapath: generic width and depth, overflow/underflow protection, true occupancy count, almost-full/almost-empty flags. Sits between the I2C byte engine and the host register interface, one instance per direction (TX, RX).

Parameters:
DATA_W, 8, data word width in bits
DEPTH_LOG2, 4, log2 of entry count; depth = 2**DEPTH_LOG2 (16)
AFULL_TH, 12, almost_full asserts when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
wr  input  1  write request
data_in  input  DATA_W  write data
rd  input  1  read request
data_out  output  DATA_W  read data, registered
rd_valid  output  1  data_out updated this cycle (1-cycle pulse)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, data_out=0, rd_valid=0, overflow=underflow=0; empty=1, almost_empty=1, full=0, almost_full=0. Memory is not cleared.
- Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0. count is held separately at DEPTH_LOG2+1 bits, so full and empty are unambiguous.
- Effective write: we = wr & ~full. Effective read: re = rd & ~empty. Blocked requests leave pointers, count and memory untouched.
- Write: on we, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read latency is 1 cycle. On re, data_out <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 the next cycle. Otherwise data_out holds its value and rd_valid=0.
- count update per cycle: we&~re gives +1; re&~we gives -1; otherwise unchanged. Count never resets to 0 except by reset. The old "else 0" behaviour is explicitly not carried over.
- Simultaneous wr and rd:
  - When empty: only the write takes effect. No bypass, the read is flagged as an underflow, and count goes 0 to 1.
  - When full: only the read takes effect, the write is flagged as an overflow, and count goes DEPTH to DEPTH-1.
  - Otherwise both take effect and count is unchanged.
- Flags are combinational from registered count, so they are valid in the cycle after the causing edge.
- overflow sets on wr&full; underflow sets on rd&empty. Both hold until clr_err=1 (clear at the edge) or reset. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-operation empties the FIFO immediately. Data in flight is lost, and rd_valid drops asynchronously.

Optional Feature:
I2C_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - data_out continuously presents mem[rd_ptr] (combinational read path).
  - rd_valid = ~empty.
  - rd acts as a pop acknowledge with 0-cycle latency.
  - A write into an empty FIFO appears on data_out the next cycle.
- Undefined: the registered 1-cycle-latency read described above.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package i2c_fifo_pkg holds:
  - function clog2
  - default localparams FIFO_DATA_W=8, FIFO_DEPTH_LOG2=4
  - localparam FIFO_DEPTH derived from FIFO_DEPTH_LOG2
- One sub-module, i2c_fifo_ram: a simple dual-port array, one write port plus one read port. It provides a registered read, or a combinational read under the FWFT macro. Pointer, count and flag logic stay in the top.

Test Plan:
- Reset, then write 0x01..0x10 (16 words): full=1 after 16th, count=16, almost_full=1 from count 12. A 17th write of 0xFF sets overflow=1, count stays 16, and no data is overwritten.
- Read 16 from full: data_out 0x01..0x10 in order, each one cycle after rd with rd_valid pulse. empty=1 after last. An extra rd sets underflow=1, data_out holds 0x10, count=0.
- Wrap-around: 10 writes, 10 reads, then 10 more writes and 10 reads. Data comes out in order across the pointer wrap, with count peaking at 10 and returning to 0.
- Simultaneous wr/rd at count=5 for 20 cycles: count stays 5 and output order is preserved. Simultaneous at empty: count becomes 1 and underflow=1. Simultaneous at full: count becomes 15 and overflow=1.
- clr_err pulse clears both sticky bits. Assert reset mid-burst at count=7: count=0, empty=1, data_out=0 asynchronously.
- With I2C_FIFO_FWFT_EN: a write of 0xA5 into empty shows data_out=0xA5, rd_valid=1 the next cycle. rd pops it with empty=1 the following cycle.
